dca_matrix_row_packer: RTL and testbench
========================================

# dca_matrix_row_packer

Registered, saturating successor to the combinational LSU row-packing path in the DCA matrix load/store unit. It accepts one unpacked matrix row per handshake, with `MATRIX_NUM_COL` elements of `BW_LSU_ELEMENT` bits each, and emits one packed memory row: element width 1/2/4/8/16/32 bits, optional saturation, and per-column masking. A one-cycle pipeline register plus skid buffer gives full throughput with a fully registered output. It sits between the LSU element datapath and the memory write-row buffer, and also counts saturation events for software.

## Interface
Parameters:
- `MATRIX_NUM_COL`, 4: elements per row (≥1).
- `BW_LSU_ELEMENT`, 32: source element width (8..64).
- `MAX_BW_ELEMENT`, 32: widest packed element; fixes the output row width.
- `BW_TXN_INFO`, 8: transaction tag width, passed through unchanged.
- `BW_SAT_COUNT`, 16: width of the saturation counter.

Ports:
- `clk`  in  1  clock.
- `rstnn`  in  1  asynchronous, active-high reset (one clock; reset is asynchronous and active-high).
- `clear`  in  1  synchronous clear of `sat_count`.
- `in_valid`  in  1  input row valid.
- `in_ready`  out  1  input row accepted when `in_valid & in_ready`.
- `in_row`  in  `BW_LSU_ELEMENT*MATRIX_NUM_COL`  unpacked elements; column i is at `[BW_LSU_ELEMENT*i +: BW_LSU_ELEMENT]`.
- `in_width_code`  in  3  log2 of the packed element width; codes 6 and 7 are treated as 5.
- `in_is_signed`  in  1  source and destination are two's complement.
- `in_saturate`  in  1  1 = clamp, 0 = truncate/extend.
- `in_col_mask`  in  `MATRIX_NUM_COL`  1 = column active, 0 = field forced to 0.
- `in_txn`  in  `BW_TXN_INFO`  tag.
- `out_valid`  out  1  packed row valid.
- `out_ready`  in  1  downstream accept.
- `out_row`  out  `MAX_BW_ELEMENT*MATRIX_NUM_COL`  packed row.
- `out_sat_mask`  out  `MATRIX_NUM_COL`  per-column "value was clamped".
- `out_txn`  out  `BW_TXN_INFO`  tag belonging to `out_row`.
- `sat_count`  out  `BW_SAT_COUNT`  count of rows with any clamped column; saturates at all-ones.

## Operation
- Packed width is W = 1<<min(`in_width_code`,5). Column i maps to `out_row[W*i +: W]`; bits at and above `W*MATRIX_NUM_COL` are 0.
- Masked column (`in_col_mask[i]=0`): field is 0 and its `out_sat_mask` bit is 0.
- `in_saturate=0`, W ≤ `BW_LSU_ELEMENT`: field is the low W bits of the source.
- `in_saturate=0`, W > `BW_LSU_ELEMENT`: field is the source sign-extended if `in_is_signed`, else zero-extended.
- `in_saturate=1`, signed: the source is clamped to [-2^(W-1), 2^(W-1)-1]. For W=1 the range is [-1,0].
- `in_saturate=1`, unsigned: the source is clamped to [0, 2^W-1].
- Saturation flag: the `out_sat_mask` bit is set only when clamping changed the value. With W ≥ `BW_LSU_ELEMENT` nothing is ever clamped.
- Packing is combinational on the input; the packed result, sat mask and tag are registered on acceptance.
- Buffering uses a main output register (M) and a skid register (S).
  - `in_ready = !S_valid & !rstnn`.
  - On accept: if M is empty or M is draining this cycle, the row loads into M. Otherwise it loads into S.
  - When M drains and S is valid, S moves to M.
  - Rows leave in acceptance order. No row is dropped or duplicated.
- `sat_count` increments by 1 on each accepted row with a nonzero sat mask and holds at all-ones.
  - If `clear` and an increment occur in the same cycle, `clear` wins and the result is 0.
  - `clear` does not affect the data path.
- Reset mid-operation discards M and S contents, including rows in flight.

## Timing
- Reset values: `out_valid`=0, `out_row`=0, `out_sat_mask`=0, `out_txn`=0, `sat_count`=0. `in_ready`=0 while `rstnn` is high and 1 from the first cycle after deassertion.
- Latency: a row accepted at edge N appears on `out_valid` and the output data after edge N, i.e. in cycle N+1.
- Throughput: one row per cycle while `out_ready`=1.
- Backpressure: with `out_ready`=0, at most 2 rows are held. `in_ready` drops in the cycle after S fills. It returns in the cycle after S transfers into M.
- Output stability: while `out_valid & !out_ready`, `out_row`, `out_sat_mask` and `out_txn` hold.
- Input fields are sampled only at the accept edge.

## Test plan
- Truncate: W=8 unsigned, no saturate, all columns active, column values 0x1FF, 0x7F, 0x80, 0x100 -> `out_row[31:0]` = 0x00807FFF, sat mask 0000, tag echoed in the next cycle.
- Signed saturate: W=4, signed, column values -9, 7, 8, -8 (32-bit) -> fields 0x8, 0x7, 0x7, 0x8, sat mask 0101, `sat_count` 0→1.
- Unsigned saturate with mask: W=2, mask 1011, column values 5, 3, 9, 1 -> fields 3, 3, 0, 1, sat mask 0001. With W=32 and `BW_LSU_ELEMENT`=16, value 0x8000 signed -> field 0xFFFF8000, sat mask 0.
- Backpressure: stream tags 1..6 with `out_ready` held low 4 cycles -> exactly rows 1 and 2 buffered, `in_ready`=0, then tags 1..6 delivered in order with no gaps once ready.
- Counter: 65537 saturating rows with `BW_SAT_COUNT`=16 -> count is 0xFFFF. Then `clear` together with a saturating row -> count is 0.
- Reset mid-stream: assert `rstnn` with both registers full -> `out_valid`=0 and `in_ready`=0 immediately. After release, the first new row appears alone with its own tag.

Source files
------------

// File: rtl/dca_matrix_row_packer_if.sv
`default_nettype none
//==============================================================================
// Module : dca_matrix_row_packer_if
// Desc   : Row-in / packed-row-out handshake bundle for the LSU row packer.
// Rev    : 1.0 - initial release
//==============================================================================
interface dca_matrix_row_packer_if #(
    parameter int MATRIX_NUM_COL = 4,
    parameter int BW_LSU_ELEMENT = 32,
    parameter int MAX_BW_ELEMENT = 32,
    parameter int BW_TXN_INFO    = 8
);
    logic                                     in_valid;
    logic                                     in_ready;
    logic [BW_LSU_ELEMENT*MATRIX_NUM_COL-1:0] in_row;
    logic [2:0]                               in_width_code;
    logic                                     in_is_signed;
    logic                                     in_saturate;
    logic [MATRIX_NUM_COL-1:0]                in_col_mask;
    logic [BW_TXN_INFO-1:0]                   in_txn;
    logic                                     out_valid;
    logic                                     out_ready;
    logic [MAX_BW_ELEMENT*MATRIX_NUM_COL-1:0] out_row;
    logic [MATRIX_NUM_COL-1:0]                out_sat_mask;
    logic [BW_TXN_INFO-1:0]                   out_txn;

    modport master (
        output in_valid, in_row, in_width_code, in_is_signed, in_saturate,
               in_col_mask, in_txn, out_ready,
        input  in_ready, out_valid, out_row, out_sat_mask, out_txn
    );

    modport slave (
        input  in_valid, in_row, in_width_code, in_is_signed, in_saturate,
               in_col_mask, in_txn, out_ready,
        output in_ready, out_valid, out_row, out_sat_mask, out_txn
    );
endinterface
`default_nettype wire

// File: rtl/dca_matrix_row_packer.sv
`default_nettype none
//==============================================================================
// Module : dca_matrix_row_packer
// Desc   : Packs one LSU matrix row into 1..32-bit fields with optional clamp,
//          column masking, registered output with skid buffer, sat counter.
// Rev    : 1.0 - initial release
//==============================================================================
module dca_matrix_row_packer #(
    parameter int MATRIX_NUM_COL = 4,
    parameter int BW_LSU_ELEMENT = 32,
    parameter int MAX_BW_ELEMENT = 32,
    parameter int BW_TXN_INFO    = 8,
    parameter int BW_SAT_COUNT   = 16
) (
    input  wire                       clk,
    input  wire                       rstnn,
    input  wire                       clear,
    dca_matrix_row_packer_if.slave    bus,
    output logic [BW_SAT_COUNT-1:0]   sat_count
);

    localparam int c_out_w  = MAX_BW_ELEMENT * MATRIX_NUM_COL;
    localparam int c_pack_w = ((MAX_BW_ELEMENT > 32) ? MAX_BW_ELEMENT : 32) * MATRIX_NUM_COL;

    logic [2:0]                w_code_eff;
    logic [6:0]                w_width;
    logic [31:0]               w_wmask;
    logic [31:0]               w_fld [MATRIX_NUM_COL];
    logic [MATRIX_NUM_COL-1:0] w_sat;
    logic [c_pack_w-1:0]       w_packed;
    logic [c_out_w-1:0]        w_row;

    logic                      w_accept;
    logic                      w_drain;

    logic                      r_m_valid;
    logic [c_out_w-1:0]        r_m_row;
    logic [MATRIX_NUM_COL-1:0] r_m_sat;
    logic [BW_TXN_INFO-1:0]    r_m_txn;
    logic                      r_s_valid;
    logic [c_out_w-1:0]        r_s_row;
    logic [MATRIX_NUM_COL-1:0] r_s_sat;
    logic [BW_TXN_INFO-1:0]    r_s_txn;
    logic [BW_SAT_COUNT-1:0]   r_cnt;

    assign w_code_eff = (bus.in_width_code > 3'd5) ? 3'd5 : bus.in_width_code;
    assign w_width    = 7'd1 << w_code_eff;
    assign w_wmask    = (w_code_eff == 3'd5) ? 32'hFFFF_FFFF : ((32'd1 << w_width) - 32'd1);

    // Each column is widened to 65 bits so one signed compare covers every
    // source width, signedness and target range.
    for (genvar gi = 0; gi < MATRIX_NUM_COL; gi++) begin : g_col
        logic [BW_LSU_ELEMENT-1:0] w_src;
        logic signed [64:0]        w_ext;
        logic signed [64:0]        w_hi;
        logic signed [64:0]        w_lo;
        logic                      w_over;
        logic                      w_under;
        logic [31:0]               w_val;

        assign w_src = bus.in_row[BW_LSU_ELEMENT*gi +: BW_LSU_ELEMENT];

        always_comb begin
            if (bus.in_is_signed) begin
                w_ext = {{(65-BW_LSU_ELEMENT){w_src[BW_LSU_ELEMENT-1]}}, w_src};
                w_hi  = (65'sd1 <<< (w_width - 7'd1)) - 65'sd1;
                w_lo  = -(65'sd1 <<< (w_width - 7'd1));
            end else begin
                w_ext = {{(65-BW_LSU_ELEMENT){1'b0}}, w_src};
                w_hi  = (65'sd1 <<< w_width) - 65'sd1;
                w_lo  = '0;
            end
        end

        assign w_over  = (w_ext > w_hi);
        assign w_under = (w_ext < w_lo);

        always_comb begin
            w_val = w_ext[31:0];
            if (bus.in_saturate && w_over) begin
                w_val = w_hi[31:0];
            end else if (bus.in_saturate && w_under) begin
                w_val = w_lo[31:0];
            end
        end

        assign w_sat[gi] = bus.in_col_mask[gi] & bus.in_saturate & (w_over | w_under);
        assign w_fld[gi] = bus.in_col_mask[gi] ? (w_val & w_wmask) : 32'd0;
    end

    always_comb begin
        w_packed = '0;
        for (int i = 0; i < MATRIX_NUM_COL; i++) begin
            w_packed = w_packed | (c_pack_w'(w_fld[i]) << (int'(w_width) * i));
        end
    end

    assign w_row = w_packed[c_out_w-1:0];

    assign w_accept     = bus.in_valid & bus.in_ready;
    assign w_drain      = r_m_valid & bus.out_ready;
    assign bus.in_ready = ~r_s_valid & ~rstnn;

    // M feeds the output; S only catches a row accepted while M is stalled.
    always_ff @(posedge clk or posedge rstnn) begin
        if (rstnn) begin
            r_m_valid <= 1'b0;
            r_m_row   <= '0;
            r_m_sat   <= '0;
            r_m_txn   <= '0;
            r_s_valid <= 1'b0;
            r_s_row   <= '0;
            r_s_sat   <= '0;
            r_s_txn   <= '0;
        end else begin
            if (w_drain || !r_m_valid) begin
                if (r_s_valid) begin
                    r_m_valid <= 1'b1;
                    r_m_row   <= r_s_row;
                    r_m_sat   <= r_s_sat;
                    r_m_txn   <= r_s_txn;
                    r_s_valid <= 1'b0;
                end else if (w_accept) begin
                    r_m_valid <= 1'b1;
                    r_m_row   <= w_row;
                    r_m_sat   <= w_sat;
                    r_m_txn   <= bus.in_txn;
                end else begin
                    r_m_valid <= 1'b0;
                end
            end else if (w_accept) begin
                r_s_valid <= 1'b1;
                r_s_row   <= w_row;
                r_s_sat   <= w_sat;
                r_s_txn   <= bus.in_txn;
            end
        end
    end

    always_ff @(posedge clk or posedge rstnn) begin
        if (rstnn) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (w_accept && (|w_sat) && (r_cnt != '1)) begin
            r_cnt <= r_cnt + BW_SAT_COUNT'(1);
        end
    end

    assign bus.out_valid    = r_m_valid;
    assign bus.out_row      = r_m_row;
    assign bus.out_sat_mask = r_m_sat;
    assign bus.out_txn      = r_m_txn;
    assign sat_count        = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dca_matrix_row_packer.sv
`default_nettype none
//==============================================================================
// Module : tb_dca_matrix_row_packer
// Desc   : Directed self-checking bench for dca_matrix_row_packer.
// Rev    : 1.0 - initial release
//==============================================================================
module tb_dca_matrix_row_packer;

    logic        clk = 1'b0;
    logic        rstnn;
    logic        clear;
    logic        clear_b;
    logic [15:0] sat_count;
    logic [15:0] sat_count_b;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          next_in;
    int          exp_tag;
    int          gaps;
    logic        fire;

    always #5 clk = ~clk;

    dca_matrix_row_packer_if #(.MATRIX_NUM_COL(4), .BW_LSU_ELEMENT(32),
        .MAX_BW_ELEMENT(32), .BW_TXN_INFO(8)) bus_a ();
    dca_matrix_row_packer_if #(.MATRIX_NUM_COL(2), .BW_LSU_ELEMENT(16),
        .MAX_BW_ELEMENT(32), .BW_TXN_INFO(8)) bus_b ();

    dca_matrix_row_packer #(.MATRIX_NUM_COL(4), .BW_LSU_ELEMENT(32),
        .MAX_BW_ELEMENT(32), .BW_TXN_INFO(8), .BW_SAT_COUNT(16)) u_dut_a (
        .clk       (clk),
        .rstnn     (rstnn),
        .clear     (clear),
        .bus       (bus_a),
        .sat_count (sat_count)
    );

    dca_matrix_row_packer #(.MATRIX_NUM_COL(2), .BW_LSU_ELEMENT(16),
        .MAX_BW_ELEMENT(32), .BW_TXN_INFO(8), .BW_SAT_COUNT(16)) u_dut_b (
        .clk       (clk),
        .rstnn     (rstnn),
        .clear     (clear_b),
        .bus       (bus_b),
        .sat_count (sat_count_b)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [2:0] code, input logic sgn, input logic sat,
                           input logic [3:0] mask, input logic [7:0] txn,
                           input logic [31:0] c0, input logic [31:0] c1,
                           input logic [31:0] c2, input logic [31:0] c3);
        bus_a.in_width_code = code;
        bus_a.in_is_signed  = sgn;
        bus_a.in_saturate   = sat;
        bus_a.in_col_mask   = mask;
        bus_a.in_txn        = txn;
        bus_a.in_row        = {c3, c2, c1, c0};
        bus_a.in_valid      = 1'b1;
    endtask

    task automatic drive_bp(input logic [7:0] tag);
        drive_a(3'd3, 1'b0, 1'b0, 4'hF, tag, {24'h0, tag}, {24'h0, tag}, {24'h0, tag}, {24'h0, tag});
    endtask

    initial begin
        rstnn = 1'b1;
        clear = 1'b0;
        clear_b = 1'b0;
        bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1; bus_a.in_row = '0;
        bus_a.in_width_code = 3'd0; bus_a.in_is_signed = 1'b0; bus_a.in_saturate = 1'b0;
        bus_a.in_col_mask = 4'h0; bus_a.in_txn = 8'h0;
        bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b1; bus_b.in_row = '0;
        bus_b.in_width_code = 3'd0; bus_b.in_is_signed = 1'b0; bus_b.in_saturate = 1'b0;
        bus_b.in_col_mask = 2'b0; bus_b.in_txn = 8'h0;

        repeat (3) cyc();
        chk("rst_out_valid", 128'(bus_a.out_valid), 128'h0);
        chk("rst_out_row", 128'(bus_a.out_row), 128'h0);
        chk("rst_sat_mask", 128'(bus_a.out_sat_mask), 128'h0);
        chk("rst_out_txn", 128'(bus_a.out_txn), 128'h0);
        chk("rst_sat_count", 128'(sat_count), 128'h0);
        chk("rst_in_ready", 128'(bus_a.in_ready), 128'h0);
        rstnn = 1'b0;
        #1;
        chk("rel_in_ready", 128'(bus_a.in_ready), 128'h1);

        // W=8 truncate
        drive_a(3'd3, 1'b0, 1'b0, 4'hF, 8'hA1, 32'h1FF, 32'h7F, 32'h80, 32'h100);
        cyc(); bus_a.in_valid = 1'b0;
        chk("trunc_valid", 128'(bus_a.out_valid), 128'h1);
        chk("trunc_row", 128'(bus_a.out_row), 128'h0080_7FFF);
        chk("trunc_sat", 128'(bus_a.out_sat_mask), 128'h0);
        chk("trunc_txn", 128'(bus_a.out_txn), 128'hA1);

        // W=4 signed saturate
        drive_a(3'd2, 1'b1, 1'b1, 4'hF, 8'hA2, 32'hFFFF_FFF7, 32'h7, 32'h8, 32'hFFFF_FFF8);
        cyc(); bus_a.in_valid = 1'b0;
        chk("ssat_row", 128'(bus_a.out_row), 128'h8778);
        chk("ssat_sat", 128'(bus_a.out_sat_mask), 128'h5);
        chk("ssat_count", 128'(sat_count), 128'h1);

        // W=2 unsigned saturate, column 2 masked
        drive_a(3'd1, 1'b0, 1'b1, 4'b1011, 8'hA3, 32'd5, 32'd3, 32'd9, 32'd1);
        cyc(); bus_a.in_valid = 1'b0;
        chk("usat_row", 128'(bus_a.out_row), 128'h4F);
        chk("usat_sat", 128'(bus_a.out_sat_mask), 128'h1);
        chk("usat_count", 128'(sat_count), 128'h2);

        // W=1 signed saturate, range [-1,0]
        drive_a(3'd0, 1'b1, 1'b1, 4'hF, 8'hA4, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFB);
        cyc(); bus_a.in_valid = 1'b0;
        chk("w1_row", 128'(bus_a.out_row), 128'hA);
        chk("w1_sat", 128'(bus_a.out_sat_mask), 128'hC);
        chk("w1_count", 128'(sat_count), 128'h3);

        // code 7 behaves as W=32: nothing can clamp
        drive_a(3'd7, 1'b1, 1'b1, 4'hF, 8'hA5, 32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 32'h7FFF_FFFF);
        cyc(); bus_a.in_valid = 1'b0;
        chk("w32_row", 128'(bus_a.out_row), 128'h7FFF_FFFF_FFFF_FFFF_1234_5678_8000_0000);
        chk("w32_sat", 128'(bus_a.out_sat_mask), 128'h0);
        chk("w32_count", 128'(sat_count), 128'h3);

        // W=16 unsigned saturate
        drive_a(3'd4, 1'b0, 1'b1, 4'hF, 8'hA6, 32'h1_0000, 32'hFFFF, 32'h0, 32'h1_2345);
        cyc(); bus_a.in_valid = 1'b0;
        chk("w16_row", 128'(bus_a.out_row), 128'hFFFF_0000_FFFF_FFFF);
        chk("w16_sat", 128'(bus_a.out_sat_mask), 128'h9);
        chk("w16_count", 128'(sat_count), 128'h4);

        // 16-bit source into 32-bit fields: extension, never clamped
        bus_b.in_width_code = 3'd5; bus_b.in_is_signed = 1'b1; bus_b.in_saturate = 1'b0;
        bus_b.in_col_mask = 2'b11; bus_b.in_txn = 8'hB1;
        bus_b.in_row = {16'h1234, 16'h8000}; bus_b.in_valid = 1'b1;
        cyc();
        chk("ext_s_row", 128'(bus_b.out_row), 128'h0000_1234_FFFF_8000);
        chk("ext_s_txn", 128'(bus_b.out_txn), 128'hB1);
        bus_b.in_saturate = 1'b1;
        cyc();
        chk("ext_sat_row", 128'(bus_b.out_row), 128'h0000_1234_FFFF_8000);
        chk("ext_sat_mask", 128'(bus_b.out_sat_mask), 128'h0);
        bus_b.in_saturate = 1'b0; bus_b.in_is_signed = 1'b0;
        cyc(); bus_b.in_valid = 1'b0;
        chk("ext_u_row", 128'(bus_b.out_row), 128'h0000_1234_0000_8000);
        chk("ext_count", 128'(sat_count_b), 128'h0);

        // backpressure: out_ready low for 4 edges while streaming tags
        cyc();
        bus_a.out_ready = 1'b0;
        next_in = 1;
        drive_bp(8'(next_in));
        for (int k = 0; k < 4; k++) begin
            fire = bus_a.in_valid & bus_a.in_ready;
            cyc();
            if (fire) begin
                next_in++;
                drive_bp(8'(next_in));
            end
        end
        chk("bp_accepted", 128'(next_in), 128'd3);
        chk("bp_in_ready", 128'(bus_a.in_ready), 128'h0);
        chk("bp_hold_txn", 128'(bus_a.out_txn), 128'h1);
        chk("bp_hold_row", 128'(bus_a.out_row), 128'h0101_0101);

        bus_a.out_ready = 1'b1;
        exp_tag = 1;
        gaps = 0;
        for (int k = 0; k < 40 && exp_tag <= 6; k++) begin
            if (bus_a.out_valid) begin
                chk("bp_order", 128'(bus_a.out_txn), 128'(exp_tag));
                exp_tag++;
            end else begin
                gaps++;
            end
            fire = bus_a.in_valid & bus_a.in_ready;
            cyc();
            if (fire) begin
                next_in++;
                if (next_in > 6) bus_a.in_valid = 1'b0;
                else drive_bp(8'(next_in));
            end
        end
        chk("bp_all_delivered", 128'(exp_tag), 128'd7);
        chk("bp_no_gaps", 128'(gaps), 128'd0);

        // reset with both registers full
        cyc();
        bus_a.out_ready = 1'b0;
        drive_bp(8'h11); cyc();
        drive_bp(8'h22); cyc();
        bus_a.in_valid = 1'b0;
        chk("full_in_ready", 128'(bus_a.in_ready), 128'h0);
        chk("full_txn", 128'(bus_a.out_txn), 128'h11);
        #2 rstnn = 1'b1;
        #1;
        chk("midrst_valid", 128'(bus_a.out_valid), 128'h0);
        chk("midrst_in_ready", 128'(bus_a.in_ready), 128'h0);
        chk("midrst_count", 128'(sat_count), 128'h0);
        cyc();
        rstnn = 1'b0;
        bus_a.out_ready = 1'b1;
        drive_bp(8'h33);
        cyc(); bus_a.in_valid = 1'b0;
        chk("postrst_valid", 128'(bus_a.out_valid), 128'h1);
        chk("postrst_txn", 128'(bus_a.out_txn), 128'h33);
        cyc();
        chk("postrst_alone", 128'(bus_a.out_valid), 128'h0);

        // saturation counter ceiling and clear priority
        drive_a(3'd2, 1'b1, 1'b1, 4'hF, 8'h55, 32'd100, 32'd0, 32'd0, 32'd0);
        cyc();
        chk("cnt_first", 128'(sat_count), 128'h1);
        repeat (65536) cyc();
        chk("cnt_ceiling", 128'(sat_count), 128'hFFFF);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        bus_a.in_valid = 1'b0;
        chk("cnt_clear_wins", 128'(sat_count), 128'h0);
        chk("clear_data_path", 128'(bus_a.out_valid), 128'h1);
        chk("clear_data_txn", 128'(bus_a.out_txn), 128'h55);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
